// File: rtl/watch_time_counter.sv
// BCD hh:mm:ss timekeeper for the watch: counts rising edges of the 1 Hz divider output
// and accepts debounced minute/hour set buttons that take precedence over a coincident tick.
module watch_time_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 655
) (
    input  logic       rst_i,
    input  logic       clk_i,
    input  logic       sec_clk_i,
    input  logic       inc_min_i,
    input  logic       inc_hr_i,
    output logic [2:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic [2:0] min_tens_o,
    output logic [3:0] min_ones_o,
    output logic [1:0] hr_tens_o,
    output logic [3:0] hr_ones_o,
    output logic       sec_pulse_o
);
    localparam logic [15:0] LOCK_LOAD = 16'(DEBOUNCE_CYCLES);

    logic [1:0] btn_raw;
    logic [1:0] press;   // [0] minute, [1] hour

    assign btn_raw = {inc_hr_i, inc_min_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic        sync1_q, sync1_d;
            logic        sync2_q, sync2_d;
            logic        edge_q, edge_d;
            logic [15:0] lock_q, lock_d;
            logic        accept;

            always_comb begin
                sync1_d = btn_raw[gi];
                sync2_d = sync1_q;
                edge_d  = sync2_q;
                accept  = sync2_q & ~edge_q & (lock_q == 16'd0);
                lock_d  = lock_q;
                if (accept) begin
                    lock_d = LOCK_LOAD;
                end else if (lock_q != 16'd0) begin
                    lock_d = lock_q - 16'd1;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    edge_q  <= 1'b0;
                    lock_q  <= 16'd0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    edge_q  <= edge_d;
                    lock_q  <= lock_d;
                end
            end

            assign press[gi] = accept;
        end
    endgenerate

    logic [3:0] sec_ones_q, sec_ones_d, sec_ones_inc;
    logic [2:0] sec_tens_q, sec_tens_d, sec_tens_inc;
    logic [3:0] min_ones_q, min_ones_d, min_ones_inc;
    logic [2:0] min_tens_q, min_tens_d, min_tens_inc;
    logic [3:0] hr_ones_q, hr_ones_d, hr_ones_inc;
    logic [1:0] hr_tens_q, hr_tens_d, hr_tens_inc;
    logic       sec_q, sec_d;
    logic       sec_pulse_q, sec_pulse_d;
    logic       sec_wrap, min_wrap, tick, any_press;

    always_comb begin
        tick      = sec_clk_i & ~sec_q;
        any_press = |press;

        sec_ones_inc = (sec_ones_q == 4'd9) ? 4'd0 : sec_ones_q + 4'd1;
        sec_tens_inc = (sec_ones_q != 4'd9) ? sec_tens_q :
                       (sec_tens_q == 3'd5) ? 3'd0 : sec_tens_q + 3'd1;
        sec_wrap     = (sec_ones_q == 4'd9) && (sec_tens_q == 3'd5);

        min_ones_inc = (min_ones_q == 4'd9) ? 4'd0 : min_ones_q + 4'd1;
        min_tens_inc = (min_ones_q != 4'd9) ? min_tens_q :
                       (min_tens_q == 3'd5) ? 3'd0 : min_tens_q + 3'd1;
        min_wrap     = (min_ones_q == 4'd9) && (min_tens_q == 3'd5);

        // 23 wraps to 00; otherwise ordinary two-digit BCD increment
        if ((hr_tens_q == 2'd2) && (hr_ones_q == 4'd3)) begin
            hr_tens_inc = 2'd0;
            hr_ones_inc = 4'd0;
        end else if (hr_ones_q == 4'd9) begin
            hr_tens_inc = hr_tens_q + 2'd1;
            hr_ones_inc = 4'd0;
        end else begin
            hr_tens_inc = hr_tens_q;
            hr_ones_inc = hr_ones_q + 4'd1;
        end

        sec_ones_d  = sec_ones_q;
        sec_tens_d  = sec_tens_q;
        min_ones_d  = min_ones_q;
        min_tens_d  = min_tens_q;
        hr_ones_d   = hr_ones_q;
        hr_tens_d   = hr_tens_q;
        sec_d       = sec_clk_i;
        sec_pulse_d = 1'b0;

        if (any_press) begin
            if (press[0]) begin
                sec_ones_d = 4'd0;
                sec_tens_d = 3'd0;
                min_ones_d = min_ones_inc;
                min_tens_d = min_tens_inc;
            end
            if (press[1]) begin
                hr_ones_d = hr_ones_inc;
                hr_tens_d = hr_tens_inc;
            end
        end else if (tick) begin
            sec_pulse_d = 1'b1;
            sec_ones_d  = sec_ones_inc;
            sec_tens_d  = sec_tens_inc;
            if (sec_wrap) begin
                min_ones_d = min_ones_inc;
                min_tens_d = min_tens_inc;
                if (min_wrap) begin
                    hr_ones_d = hr_ones_inc;
                    hr_tens_d = hr_tens_inc;
                end
            end
        end
    end

    // sec_q resets high so a divider already high at release does not tick
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sec_ones_q  <= 4'd0;
            sec_tens_q  <= 3'd0;
            min_ones_q  <= 4'd0;
            min_tens_q  <= 3'd0;
            hr_ones_q   <= 4'd0;
            hr_tens_q   <= 2'd0;
            sec_q       <= 1'b1;
            sec_pulse_q <= 1'b0;
        end else begin
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            min_ones_q  <= min_ones_d;
            min_tens_q  <= min_tens_d;
            hr_ones_q   <= hr_ones_d;
            hr_tens_q   <= hr_tens_d;
            sec_q       <= sec_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign sec_ones_o  = sec_ones_q;
    assign sec_tens_o  = sec_tens_q;
    assign min_ones_o  = min_ones_q;
    assign min_tens_o  = min_tens_q;
    assign hr_ones_o   = hr_ones_q;
    assign hr_tens_o   = hr_tens_q;
    assign sec_pulse_o = sec_pulse_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Scoreboard bench for watch_time_counter: expected time/pulse pushed when stimulus is
// driven, popped and compared after the corresponding clock edge.
module tb_watch_time_counter;
    localparam int DEB = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sec_clk_i = 1'b1;
    logic       inc_min_i = 1'b0;
    logic       inc_hr_i = 1'b0;
    logic [2:0] sec_tens_o;
    logic [3:0] sec_ones_o;
    logic [2:0] min_tens_o;
    logic [3:0] min_ones_o;
    logic [1:0] hr_tens_o;
    logic [3:0] hr_ones_o;
    logic       sec_pulse_o;

    watch_time_counter #(.DEBOUNCE_CYCLES(DEB)) dut (
        .rst_i       (rst_i),
        .clk_i       (clk_i),
        .sec_clk_i   (sec_clk_i),
        .inc_min_i   (inc_min_i),
        .inc_hr_i    (inc_hr_i),
        .sec_tens_o  (sec_tens_o),
        .sec_ones_o  (sec_ones_o),
        .min_tens_o  (min_tens_o),
        .min_ones_o  (min_ones_o),
        .hr_tens_o   (hr_tens_o),
        .hr_ones_o   (hr_ones_o),
        .sec_pulse_o (sec_pulse_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [23:0] t;
        logic        p;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total_cnt = 0;
    int    bad_cnt = 0;
    int    eh = 0, em = 0, es = 0;

    logic [23:0] obs_t;
    assign obs_t = {2'b0, hr_tens_o, hr_ones_o, 1'b0, min_tens_o, min_ones_o,
                    1'b0, sec_tens_o, sec_ones_o};

    function automatic logic [23:0] bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        if (obs !== expv) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic p);
        exp_q.push_back('{t: bcd(eh, em, es), p: p});
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input bit verbose);
        exp_t  e;
        string tg;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e  = exp_q.pop_front();
        tg = tag_q.pop_front();
        chk($sformatf("%s/time", tg), 32'(obs_t), 32'(e.t));
        chk($sformatf("%s/pulse", tg), 32'(sec_pulse_o), 32'(e.p));
        if (verbose)
            $display("[%0t] %-14s time=%06h pulse=%0b exp=%06h/%0b", $time, tg, obs_t,
                     sec_pulse_o, e.t, e.p);
    endtask

    task automatic m_tick();
        es++;
        if (es == 60) begin es = 0; em++; end
        if (em == 60) begin em = 0; eh++; end
        if (eh == 24) eh = 0;
    endtask

    task automatic m_min();
        es = 0;
        em = (em + 1) % 60;
    endtask

    task automatic m_hr();
        eh = (eh + 1) % 24;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        sec_clk_i = 1'b1;
        inc_min_i = 1'b0;
        inc_hr_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        eh = 0; em = 0; es = 0;
    endtask

    // Tick: pulse and new time after edge N, pulse gone one cycle later
    task automatic do_tick(input string tag, input bit verbose);
        sec_clk_i = 1'b0;
        @(negedge clk_i);
        sec_clk_i = 1'b1;
        m_tick();
        push(tag, 1'b1);
        @(negedge clk_i);
        pop_check(verbose);
        push($sformatf("%s+1", tag), 1'b0);
        @(negedge clk_i);
        pop_check(1'b0);
    endtask

    // Press: unchanged for two edges, applied at the third
    task automatic do_press(input string tag, input bit mn, input bit hr,
                            input bit wait_lock, input bit verbose);
        push($sformatf("%s-k", tag), 1'b0);
        inc_min_i = mn;
        inc_hr_i  = hr;
        @(negedge clk_i);
        pop_check(1'b0);
        push($sformatf("%s-k1", tag), 1'b0);
        @(negedge clk_i);
        pop_check(1'b0);
        if (mn) m_min();
        if (hr) m_hr();
        push(tag, 1'b0);
        @(negedge clk_i);
        pop_check(verbose);
        inc_min_i = 1'b0;
        inc_hr_i  = 1'b0;
        if (wait_lock) repeat (DEB + 1) @(negedge clk_i);
    endtask

    task automatic preload(input int h, input int m, input int s);
        do_reset();
        for (int i = 0; i < h; i++) do_press("pre_hr", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < m; i++) do_press("pre_min", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < s; i++) do_tick("pre_tick", 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc [0:31];
        int last_acc;
        int n_acc;
        bit lvl;

        // Reset with divider high, then no tick while it stays high
        @(negedge clk_i);
        push("reset", 1'b0);
        pop_check(1'b1);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push("hold_high", 1'b0);
            @(negedge clk_i);
            pop_check(1'b0);
        end
        do_tick("first_tick", 1'b1);

        // Full rollover
        preload(23, 59, 59);
        do_tick("rollover", 1'b1);
        chk("roll_hr_tens", 32'(hr_tens_o), 32'd0);
        chk("roll_hr_ones", 32'(hr_ones_o), 32'd0);

        // Minute set with a long hold: no auto-repeat
        preload(12, 34, 56);
        push("min_set-k", 1'b0);
        inc_min_i = 1'b1;
        @(negedge clk_i);
        pop_check(1'b0);
        push("min_set-k1", 1'b0);
        @(negedge clk_i);
        pop_check(1'b0);
        m_min();
        push("min_set", 1'b0);
        @(negedge clk_i);
        pop_check(1'b1);
        for (int i = 0; i < 10; i++) begin
            push("min_hold", 1'b0);
            repeat (100) @(negedge clk_i);
            pop_check(1'b0);
        end
        inc_min_i = 1'b0;
        repeat (DEB + 4) @(negedge clk_i);

        preload(12, 59, 30);
        do_press("min_wrap", 1'b1, 1'b0, 1'b1, 1'b1);

        // Debounce: hour button toggled every 2 cycles for 20 cycles
        preload(5, 0, 0);
        foreach (acc[i]) acc[i] = 1'b0;
        last_acc = -100;
        n_acc = 0;
        for (int i = 0; i < 20; i += 4) begin
            if (i + 2 >= last_acc + DEB + 1) begin
                acc[i + 2] = 1'b1;
                last_acc = i + 2;
                n_acc++;
            end
        end
        for (int i = 0; i < 24; i++) begin
            lvl = (i < 20) && (((i / 2) % 2) == 0);
            inc_hr_i = lvl;
            if (acc[i]) m_hr();
            push($sformatf("deb_c%0d", i), 1'b0);
            @(negedge clk_i);
            pop_check(acc[i]);
        end
        inc_hr_i = 1'b0;
        chk("deb_hours", 32'(hr_ones_o), 32'(5 + n_acc));

        preload(23, 0, 0);
        do_press("hr_wrap", 1'b0, 1'b1, 1'b1, 1'b1);

        // Press coincident with a divider rising edge
        preload(10, 10, 10);
        sec_clk_i = 1'b0;
        push("sim-k", 1'b0);
        inc_min_i = 1'b1;
        @(negedge clk_i);
        pop_check(1'b0);
        push("sim-k1", 1'b0);
        @(negedge clk_i);
        pop_check(1'b0);
        sec_clk_i = 1'b1;
        m_min();
        push("sim_press_tick", 1'b0);
        @(negedge clk_i);
        pop_check(1'b1);
        inc_min_i = 1'b0;
        push("sim_after", 1'b0);
        @(negedge clk_i);
        pop_check(1'b0);
        repeat (DEB + 2) @(negedge clk_i);

        preload(23, 59, 40);
        do_press("both", 1'b1, 1'b1, 1'b1, 1'b1);

        // Async reset mid-count with hour lockout active
        preload(6, 45, 33);
        do_press("pre_async", 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        eh = 0; em = 0; es = 0;
        push("async_rst", 1'b0);
        #1;
        pop_check(1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        do_press("post_rst_hr", 1'b0, 1'b1, 1'b1, 1'b1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
